vga_timing_controller: RTL and testbench

Sequences the VGA display pipeline from the single system clock. Generates the 640x480 @ 60 Hz (800x525 total) horizontal/vertical timing, derives the pixel-rate enable internally, and gives the game logic a vertical-blank update window through a req/ack handshake. Sits between the system clock and the pixel renderer / DAC output stage.

---
 rtl/vga_timing_pkg.sv | 45 ++++
 rtl/pixel_tick_gen.sv | 35 +++
 rtl/vga_timing_controller.sv | 178 +++++++++++++++++
 tb/tb_vga_timing_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants, count type and vertical-phase encoding for the VGA timing block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_timing_pkg;

    // 10 bits covers both 0..799 columns and 0..524 lines.
    typedef logic [9:0] count_t;

    localparam count_t CNT_ONE = 10'd1;

    // Default system clocks per pixel tick.
    localparam int unsigned VGA_DIV = 2;

    // 640x480 @ 60 Hz segment lengths.
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FRONT  = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Sync pulse spans [start, end): 656..751 and 490..491 at the defaults.
    localparam int unsigned VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FRONT;
    localparam int unsigned VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
    localparam int unsigned VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FRONT;
    localparam int unsigned VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } vphase_t;

    // Half-open range test used for the sync decodes.
    function automatic logic in_range(input count_t x, input count_t lo, input count_t hi_excl);
        return (x >= lo) && (x < hi_excl);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Divides the system clock down to a one-clock pixel_tick pulse every DIV clocks.
// Latency: first tick DIV clocks after reset release, then one tick every DIV clocks.
// Backpressure: none; free-running.
// Ports: i_clock (system clock), i_reset_n (async active-low reset),
//        o_pixel_tick (registered one-clock pulse).
module pixel_tick_gen #(
    parameter int unsigned DIV = 2
) (
    input  logic i_clock,
    input  logic i_reset_n,
    output logic o_pixel_tick
);

    // DIV = 1 still needs a one-bit counter so the vector is never zero width.
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_div_cnt;
    logic          r_tick;

    // The tick is registered off the counter's last state so it is a clean
    // flop output and lands exactly DIV clocks after reset release.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_tick    <= (r_div_cnt == LAST);
            r_div_cnt <= (r_div_cnt == LAST) ? '0 : r_div_cnt + CW'(1);
        end
    end

    assign o_pixel_tick = r_tick;

endmodule

// File: rtl/vga_timing_controller.sv
// VGA raster timing (h/v counters, syncs, active window) plus a vblank update req/ack handshake.
// Latency: counters and decoded outputs update 1 clock after pixel_tick; req drops 1 clock after ack.
// Backpressure: none on the raster; an unacknowledged request is dropped at vblank end and counted as overrun.
// Ports: clock, reset_n (async active-low); pixel_tick, h_count, v_count, hsync, vsync,
//        display_active, frame_start (raster outputs); update_req/update_ack (handshake);
//        overrun (pulse), overrun_count (saturating 8-bit).
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int unsigned DIV      = VGA_DIV,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FRONT  = VGA_H_FRONT,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BACK   = VGA_H_BACK,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FRONT  = VGA_V_FRONT,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BACK   = VGA_V_BACK
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic       pixel_tick,
    output count_t     h_count,
    output count_t     v_count,
    output logic       hsync,
    output logic       vsync,
    output logic       display_active,
    output logic       frame_start,
    output logic       update_req,
    input  logic       update_ack,
    output logic       overrun,
    output logic [7:0] overrun_count
);

    localparam count_t H_ACT  = count_t'(H_ACTIVE);
    localparam count_t H_SS   = count_t'(H_ACTIVE + H_FRONT);
    localparam count_t H_SE   = count_t'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam count_t H_LAST = count_t'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam count_t V_ACT  = count_t'(V_ACTIVE);
    localparam count_t V_SS   = count_t'(V_ACTIVE + V_FRONT);
    localparam count_t V_SE   = count_t'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam count_t V_LAST = count_t'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

    logic       w_pixel_tick;
    logic       w_h_wrap;
    count_t     w_h_next;
    count_t     w_v_next;

    count_t     r_h_count;
    count_t     r_v_count;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_display_active;
    logic       r_frame_start;

    vphase_t    r_phase;
    vphase_t    w_phase_next;
    logic       w_enter_front;
    logic       w_enter_active;

    logic       r_update_req;
    logic       r_overrun;
    logic [7:0] r_overrun_count;
    logic       w_req_next;
    logic       w_ovr_next;
    logic [7:0] w_cnt_next;

    pixel_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .i_clock      (clock),
        .i_reset_n    (reset_n),
        .o_pixel_tick (w_pixel_tick)
    );

    // Next-count values; only committed on a pixel tick.
    assign w_h_wrap = (r_h_count == H_LAST);
    assign w_h_next = w_h_wrap ? '0 : r_h_count + CNT_ONE;
    assign w_v_next = !w_h_wrap ? r_v_count :
                      ((r_v_count == V_LAST) ? '0 : r_v_count + CNT_ONE);

    // Raster counters and decodes. Decoding from the next-count values keeps
    // every registered output aligned with the counts shown in the same clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_h_count        <= '0;
            r_v_count        <= '0;
            r_hsync          <= 1'b1;
            r_vsync          <= 1'b1;
            r_display_active <= 1'b0;
            r_frame_start    <= 1'b0;
        end else if (w_pixel_tick) begin
            r_h_count        <= w_h_next;
            r_v_count        <= w_v_next;
            r_hsync          <= !in_range(w_h_next, H_SS, H_SE);
            r_vsync          <= !in_range(w_v_next, V_SS, V_SE);
            r_display_active <= (w_h_next < H_ACT) && (w_v_next < V_ACT);
            r_frame_start    <= (w_h_next == '0) && (w_v_next == '0);
        end else begin
            r_frame_start    <= 1'b0;
        end
    end

    // Vertical phase register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= ACTIVE;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Phase transitions happen only on the tick where a line wraps into the
    // first line of the next segment.
    always_comb begin
        w_phase_next   = r_phase;
        w_enter_front  = 1'b0;
        w_enter_active = 1'b0;
        if (w_pixel_tick && w_h_wrap) begin
            unique case (r_phase)
                ACTIVE: if (w_v_next == V_ACT) begin
                    w_phase_next  = FRONT;
                    w_enter_front = 1'b1;
                end
                FRONT:  if (w_v_next == V_SS) w_phase_next = SYNC;
                SYNC:   if (w_v_next == V_SE) w_phase_next = BACK;
                BACK:   if (w_v_next == '0) begin
                    w_phase_next   = ACTIVE;
                    w_enter_active = 1'b1;
                end
                default: w_phase_next = ACTIVE;
            endcase
        end
    end

    // Handshake: an ack seen while the request is up always wins, including
    // in the clock where the window closes, so no overrun is raised then.
    always_comb begin
        w_req_next = r_update_req;
        w_ovr_next = 1'b0;
        w_cnt_next = r_overrun_count;
        if (r_update_req && update_ack) begin
            w_req_next = 1'b0;
        end else if (r_update_req && w_enter_active) begin
            w_req_next = 1'b0;
            w_ovr_next = 1'b1;
            if (r_overrun_count != 8'hFF) begin
                w_cnt_next = r_overrun_count + 8'd1;
            end
        end else if (w_enter_front) begin
            w_req_next = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_update_req    <= 1'b0;
            r_overrun       <= 1'b0;
            r_overrun_count <= 8'd0;
        end else begin
            r_update_req    <= w_req_next;
            r_overrun       <= w_ovr_next;
            r_overrun_count <= w_cnt_next;
        end
    end

    assign pixel_tick     = w_pixel_tick;
    assign h_count        = r_h_count;
    assign v_count        = r_v_count;
    assign hsync          = r_hsync;
    assign vsync          = r_vsync;
    assign display_active = r_display_active;
    assign frame_start    = r_frame_start;
    assign update_req     = r_update_req;
    assign overrun        = r_overrun;
    assign overrun_count  = r_overrun_count;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Self-checking bench for vga_timing_controller using a shrunken raster (10x8, DIV=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_timing_controller;

    localparam int DIV = 2;
    localparam int HA = 4, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 10
    localparam int VT = VA + VF + VS + VB;   // 8
    localparam int FRAME_CLK = HT * VT * DIV; // 160

    logic       clock = 1'b0;
    logic       reset_n = 1'b1;
    logic       update_ack = 1'b0;
    logic       pixel_tick, hsync, vsync, display_active, frame_start, update_req, overrun;
    logic [9:0] h_count, v_count;
    logic [7:0] overrun_count;

    int errors = 0;
    int checks = 0;

    vga_timing_controller #(
        .DIV(DIV), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pixel_tick     (pixel_tick),
        .h_count        (h_count),
        .v_count        (v_count),
        .hsync          (hsync),
        .vsync          (vsync),
        .display_active (display_active),
        .frame_start    (frame_start),
        .update_req     (update_req),
        .update_ack     (update_ack),
        .overrun        (overrun),
        .overrun_count  (overrun_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_hv(input string name, input int h, input int v);
        bit seen = 1'b0;
        for (int k = 0; k < 2 * FRAME_CLK && !seen; k++) begin
            @(posedge clock); #2;
            seen = (int'(h_count) == h) && (int'(v_count) == v);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: counters never reached (%0d,%0d), got (%0d,%0d)",
                     name, h, v, h_count, v_count);
        end
    endtask

    task automatic wait_fs(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < 2 * FRAME_CLK && !seen; k++) begin
            @(posedge clock); #2;
            seen = frame_start;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: frame_start not seen within %0d clocks, got 0 expected 1",
                     name, 2 * FRAME_CLK);
        end
    endtask

    // Reference model: everything follows from the number of clocks since reset
    // release. Ticks land on clocks DIV, 2*DIV, ...; the raster position is the
    // tick count folded into columns and lines.
    int m_c = 0;
    bit m_req = 1'b0;
    int m_cnt = 0;

    initial begin : compare
        logic ack_s, rst_s;
        int   n, h, v;
        bit   changed, e_front, e_act, m_ovr, m_tick, m_hs, m_vs, m_act;
        forever begin
            @(posedge clock);
            ack_s = update_ack;
            rst_s = reset_n;
            #1;
            if (!rst_s) begin
                m_c = 0; m_req = 1'b0; m_cnt = 0;
            end else begin
                m_c++;
            end
            n       = (m_c >= 1) ? (m_c - 1) / DIV : 0;
            h       = n % HT;
            v       = (n / HT) % VT;
            m_tick  = (m_c >= 1) && (m_c % DIV == 0);
            changed = (m_c >= 2) && ((m_c - 1) % DIV == 0);
            e_front = changed && (h == 0) && (v == VA);
            e_act   = changed && (h == 0) && (v == 0);
            m_hs    = !((h >= HA + HF) && (h < HA + HF + HS));
            m_vs    = !((v >= VA + VF) && (v < VA + VF + VS));
            m_act   = (n > 0) && (h < HA) && (v < VA);
            m_ovr   = 1'b0;
            if (m_req && ack_s) begin
                m_req = 1'b0;
            end else if (m_req && e_act) begin
                m_req = 1'b0;
                m_ovr = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end else if (e_front) begin
                m_req = 1'b1;
            end
            chk("pixel_tick", int'(pixel_tick), int'(m_tick));
            chk("h_count", int'(h_count), h);
            chk("v_count", int'(v_count), v);
            chk("hsync", int'(hsync), int'(m_hs));
            chk("vsync", int'(vsync), int'(m_vs));
            chk("display_active", int'(display_active), int'(m_act));
            chk("frame_start", int'(frame_start), int'(e_act));
            chk("update_req", int'(update_req), int'(m_req));
            chk("overrun", int'(overrun), int'(m_ovr));
            chk("overrun_count", int'(overrun_count), m_cnt);
        end
    end

    initial begin : stim
        int hs_lo, vs_lo, act, fs, hmin, hmax, vmin, vmax, ovr_seen;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;

        // First tick DIV clocks after release; defaults hold until then.
        @(posedge clock); #2;
        chk("tick_clk1", int'(pixel_tick), 0);
        chk("h_clk1", int'(h_count), 0);
        @(posedge clock); #2;
        chk("tick_clk2", int'(pixel_tick), 1);
        chk("active_clk2", int'(display_active), 0);
        @(posedge clock); #2;
        chk("h_clk3", int'(h_count), 1);
        chk("active_clk3", int'(display_active), 1);

        // No ack in the first frame: overrun at the first (0,0).
        wait_fs("first_frame");
        chk("first_ovr", int'(overrun), 1);
        chk("first_ovr_cnt", int'(overrun_count), 1);

        // One full frame of raster statistics.
        hs_lo = 0; vs_lo = 0; act = 0; fs = 0;
        hmin = 999; hmax = -1; vmin = 999; vmax = -1;
        for (int k = 0; k < FRAME_CLK; k++) begin
            @(posedge clock); #2;
            if (!hsync) begin
                hs_lo++;
                if (int'(h_count) < hmin) hmin = int'(h_count);
                if (int'(h_count) > hmax) hmax = int'(h_count);
            end
            if (!vsync) begin
                vs_lo++;
                if (int'(v_count) < vmin) vmin = int'(v_count);
                if (int'(v_count) > vmax) vmax = int'(v_count);
            end
            if (display_active) act++;
            if (frame_start) fs++;
        end
        chk("hsync_low_clocks", hs_lo, 32);
        chk("hsync_low_hmin", hmin, 6);
        chk("hsync_low_hmax", hmax, 7);
        chk("vsync_low_clocks", vs_lo, 40);
        chk("vsync_low_vmin", vmin, 5);
        chk("vsync_low_vmax", vmax, 6);
        chk("active_clocks", act, 32);
        chk("frame_starts", fs, 1);

        // Ack mid-vblank: request drops next clock, no overrun at frame end.
        wait_hv("req_window", 0, VA);
        chk("req_rise", int'(update_req), 1);
        wait_hv("ack_point", 0, VA + VF + 1);
        update_ack = 1'b1;
        @(posedge clock); #2;
        chk("req_after_ack", int'(update_req), 0);
        update_ack = 1'b0;
        wait_fs("after_ack");
        chk("ovr_after_ack", int'(overrun), 0);
        chk("cnt_after_ack", int'(overrun_count), 2);

        // Ack in the same clock the window closes.
        wait_hv("last_pixel", HT - 1, VT - 1);
        @(posedge clock); #2;
        chk("tick_before_wrap", int'(pixel_tick), 1);
        update_ack = 1'b1;
        @(posedge clock); #2;
        update_ack = 1'b0;
        chk("simul_fs", int'(frame_start), 1);
        chk("simul_req", int'(update_req), 0);
        chk("simul_ovr", int'(overrun), 0);
        chk("simul_cnt", int'(overrun_count), 2);

        // Random acks across many frames.
        for (int k = 0; k < 30 * FRAME_CLK; k++) begin
            @(negedge clock);
            update_ack = ($urandom_range(0, 49) == 0);
        end
        @(negedge clock);
        update_ack = 1'b0;

        // Never ack: the counter saturates.
        repeat (260 * FRAME_CLK) @(posedge clock);
        wait_fs("saturate");
        chk("sat_ovr", int'(overrun), 1);
        chk("sat_cnt", int'(overrun_count), 255);

        // Reset while a request is pending.
        wait_hv("reset_point", 3, VA);
        chk("req_before_reset", int'(update_req), 1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rst_tick", int'(pixel_tick), 0);
        chk("rst_h", int'(h_count), 0);
        chk("rst_v", int'(v_count), 0);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_active", int'(display_active), 0);
        chk("rst_fs", int'(frame_start), 0);
        chk("rst_req", int'(update_req), 0);
        chk("rst_ovr", int'(overrun), 0);
        chk("rst_cnt", int'(overrun_count), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        update_ack = 1'b1;
        ovr_seen = 0;
        for (int k = 0; k < FRAME_CLK + 4; k++) begin
            @(posedge clock); #2;
            if (overrun) ovr_seen++;
        end
        chk("no_ovr_after_reset", ovr_seen, 0);
        update_ack = 1'b0;
        repeat (2 * FRAME_CLK) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
